// File: rtl/nibble_serial_addsub_ctrl_if.sv
// nibble_serial_addsub_ctrl_if
// Request/response bundle between a requester and the nibble-serial
// add/subtract sequencer. The requester drives start/op_sub/a/b and
// watches busy/done/result/carry_out.
// Optional macro OVF_DETECT_EN adds the signed overflow flag to the bundle.

interface nibble_serial_addsub_ctrl_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;

`ifdef OVF_DETECT_EN
   logic             overflow;

   modport master (
      output start, op_sub, a, b,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, op_sub, a, b,
      output busy, done, result, carry_out, overflow
   );
`else
   modport master (
      output start, op_sub, a, b,
      input  busy, done, result, carry_out
   );

   modport slave (
      input  start, op_sub, a, b,
      output busy, done, result, carry_out
   );
`endif

endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
// Multi-word add/subtract sequencer that time-shares one 4-bit ripple-carry
// slice (four_bit_rca), processing the operands one nibble per clock, LSB
// nibble first, with the carry held in a register between nibbles.
// Subtraction is a + ~b + 1: B is one's-complemented at latch time and the
// carry register is preloaded with 1.
// Optional macro OVF_DETECT_EN adds a registered signed-overflow flag.
// WIDTH must be a multiple of 4 and at least 4.

module four_bit_rca (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] S,
   output logic       Cout
);

   logic [4:0] carryChain;

   // Plain ripple of four full adders, purely combinational
   always_comb begin
      carryChain    = '0;
      S             = '0;
      carryChain[0] = Cin;
      for (int i = 0; i < 4; i++) begin
         S[i]            = A[i] ^ B[i] ^ carryChain[i];
         carryChain[i+1] = (A[i] & B[i]) | (carryChain[i] & (A[i] ^ B[i]));
      end
      Cout = carryChain[4];
   end

endmodule

module nibble_serial_addsub_ctrl #(
   parameter int WIDTH = 16
) (
   input logic                        clk,
   input logic                        rst,
   nibble_serial_addsub_ctrl_if.slave bus
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            state;
   stateT            nextState;

   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] resultReg;
   logic             carryReg;
   logic             carryOutReg;
   logic [IDXW-1:0]  nibbleIdx;

   logic             accept;
   logic             finalEdge;

   logic [3:0]       nibA;
   logic [3:0]       nibB;
   logic [3:0]       nibS;
   logic             nibCout;

   // The slice only ever sees registered values, so no input port reaches an output combinationally
   assign nibA = opA[{nibbleIdx, 2'b00} +: 4];
   assign nibB = opB[{nibbleIdx, 2'b00} +: 4];

   four_bit_rca slice (
      .A    (nibA),
      .B    (nibB),
      .Cin  (carryReg),
      .S    (nibS),
      .Cout (nibCout)
   );

   // State register; reset drops straight back to IDLE even mid-operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode: start is only honoured in IDLE, RUN ends on the top nibble
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      finalEdge = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            if (nibbleIdx == LAST_IDX) begin
               finalEdge = 1'b1;
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Operand latch on accept, then one nibble of result and carry per RUN clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opA         <= '0;
         opB         <= '0;
         resultReg   <= '0;
         carryReg    <= 1'b0;
         carryOutReg <= 1'b0;
         nibbleIdx   <= '0;
      end else if (accept) begin
         opA       <= bus.a;
         opB       <= bus.op_sub ? ~bus.b : bus.b;
         carryReg  <= bus.op_sub;
         nibbleIdx <= '0;
      end else if (state == RUN) begin
         resultReg[{nibbleIdx, 2'b00} +: 4] <= nibS;
         carryReg                           <= nibCout;
         if (finalEdge) begin
            carryOutReg <= nibCout;
         end else begin
            nibbleIdx <= nibbleIdx + 1'b1;
         end
      end
   end

`ifdef OVF_DETECT_EN
   logic ovfReg;

   // Signed overflow: same-sign operands producing a result of the other sign
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovfReg <= 1'b0;
      end else if ((state == RUN) && finalEdge) begin
         ovfReg <= (opA[WIDTH-1] == opB[WIDTH-1]) && (nibS[3] != opA[WIDTH-1]);
      end
   end

   assign bus.overflow = ovfReg;
`endif

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.result    = resultReg;
   assign bus.carry_out = carryOutReg;

endmodule
